// File: rtl/mem_arbiter.sv
// Round-robin arbiter with per-requester lock for the shared single-port cons-cell memory.
// Optional build macro MEM_ARB_BOUNDS_CHECK_EN: suppress and flag accesses at addresses >= MEM_DEPTH.
module mem_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_REQ-1:0]            err,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              owner_vld_q, owner_vld_d;
  logic [IDX_W-1:0]  owner_idx_q, owner_idx_d;
  logic              rsp_vld_q, rsp_we_q, rsp_err_q;
  logic [IDX_W-1:0]  rsp_idx_q;

  logic              grant_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  cand;
  logic              sel_we, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              oob;

  // Winner selection; gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    gnt       = '0;
    grant_vld = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    if (rst_n) begin
      if (owner_vld_q) begin
        if (req[owner_idx_q]) begin
          grant_vld = 1'b1;
          sel_idx   = owner_idx_q;
        end
      end else begin
        for (int off = 1; off <= NUM_REQ; off++) begin
          cand = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
          if (!grant_vld && req[cand]) begin
            grant_vld = 1'b1;
            sel_idx   = cand;
          end
        end
      end
      if (grant_vld) gnt[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_we    = we[i];
        sel_lock  = lock[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  assign oob = grant_vld && (32'(sel_addr) >= 32'(MEM_DEPTH));
`else
  assign oob = 1'b0;
  // High address bits are deliberately dropped: the access wraps into physical memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_addr[ADDR_W-1:MEM_AW];
`endif

  assign mem_en    = grant_vld && !oob;
  assign mem_we    = mem_en && sel_we;
  assign mem_addr  = mem_en ? sel_addr[MEM_AW-1:0] : '0;
  assign mem_wdata = mem_en ? sel_wdata : '0;

  // Ownership: taken or dropped by a granted access, or dropped by an idle owner with lock low.
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_idx_d = owner_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_vld) begin
      owner_vld_d = sel_lock;
      owner_idx_d = sel_idx;
      rr_ptr_d    = sel_idx;
    end else if (owner_vld_q && !req[owner_idx_q] && !lock[owner_idx_q]) begin
      owner_vld_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      owner_vld_q <= 1'b0;
      owner_idx_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_idx_q <= owner_idx_d;
      rsp_vld_q   <= grant_vld;
      rsp_idx_q   <= sel_idx;
      rsp_we_q    <= sel_we;
      rsp_err_q   <= oob;
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_vld_q && (rsp_idx_q == IDX_W'(i))) rvalid[i] = 1'b1;
    end
  end

  // Writes and rejected accesses acknowledge with zero data.
  assign rdata = (rsp_vld_q && !rsp_we_q && !rsp_err_q) ? mem_rdata : '0;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  assign err = rsp_err_q ? rvalid : '0;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, lock, we;
  logic [35:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt, rvalid, err;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] tbmem [256];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(16), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr];
    end
  end

  typedef struct {
    logic [2:0]  req, lock, we;
    logic [11:0] a0, a1, a2;
    logic [15:0] wd;
    logic [2:0]  gnt;
    logic        en, mwe;
    logic [7:0]  maddr;
    logic [15:0] mwd;
    logic [2:0]  rv;
    logic [15:0] rd;
    logic [2:0]  er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [2:0] r, l, w, input logic [11:0] a0, a1, a2, input logic [15:0] wd,
    input logic [2:0] g, input logic en, mwe, input logic [7:0] ma, input logic [15:0] mwd,
    input logic [2:0] rv, input logic [15:0] rd, input logic [2:0] er);
    vec_t v;
    v.req = r; v.lock = l; v.we = w; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd = wd;
    v.gnt = g; v.en = en; v.mwe = mwe; v.maddr = ma; v.mwd = mwd; v.rv = rv; v.rd = rd; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, l, w, input logic [11:0] a0, a1, a2, input logic [15:0] wd);
    req = r; lock = l; we = w; addr = {a2, a1, a0}; wdata = {3{wd}};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, 32'(gnt), 0);
    check({tag, " rvalid"}, 32'(rvalid), 0);
    check({tag, " rdata"}, 32'(rdata), 0);
    check({tag, " err"}, 32'(err), 0);
    check({tag, " mem"}, {7'd0, mem_en, mem_we, mem_addr, mem_wdata}, 0);
  endtask

  localparam logic       BC_EN  = `ifdef MEM_ARB_BOUNDS_CHECK_EN 1'b0 `else 1'b1 `endif;
  localparam logic [2:0] BC_ERR = `ifdef MEM_ARB_BOUNDS_CHECK_EN 3'b100 `else 3'b000 `endif;
  localparam logic [15:0] BC_RD = `ifdef MEM_ARB_BOUNDS_CHECK_EN 16'h0000 `else 16'hBEEF `endif;

  initial begin
    for (int i = 0; i < 256; i++) tbmem[i] = 16'h0;
    tbmem[0] = 16'hBEEF; tbmem[1] = 16'hDEAD; tbmem[2] = 16'h2222; tbmem[5] = 16'h5555;
    mem_rdata = 16'h0;

    // Requests are driven during reset to show gnt is held low.
    rst_n = 1'b0;
    drive(3'b111, 3'b000, 3'b000, 12'h001, 12'h002, 12'h005, 16'h0);
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    //        req     lock    we      a0      a1      a2      wd        gnt     en    mwe   maddr  mwd       rv      rd        err
    vecs.push_back(mk(3'b001, 3'b000, 3'b000, 12'h001, 12'h000, 12'h000, 16'h0000, 3'b001, 1'b1, 1'b0, 8'h01, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b001, 16'hDEAD, 3'b000));
    vecs.push_back(mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h002, 16'h0000, 3'b100, 1'b1, 1'b0, 8'h02, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 12'h005, 12'h001, 12'h002, 16'h0000, 3'b001, 1'b1, 1'b0, 8'h05, 16'h0000, 3'b100, 16'h2222, 3'b000));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 12'h005, 12'h001, 12'h002, 16'h0000, 3'b010, 1'b1, 1'b0, 8'h01, 16'h0000, 3'b001, 16'h5555, 3'b000));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 12'h005, 12'h001, 12'h002, 16'h0000, 3'b100, 1'b1, 1'b0, 8'h02, 16'h0000, 3'b010, 16'hDEAD, 3'b000));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 12'h005, 12'h001, 12'h002, 16'h0000, 3'b001, 1'b1, 1'b0, 8'h05, 16'h0000, 3'b100, 16'h2222, 3'b000));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 12'h005, 12'h001, 12'h002, 16'h0000, 3'b010, 1'b1, 1'b0, 8'h01, 16'h0000, 3'b001, 16'h5555, 3'b000));
    vecs.push_back(mk(3'b111, 3'b000, 3'b000, 12'h005, 12'h001, 12'h002, 16'h0000, 3'b100, 1'b1, 1'b0, 8'h02, 16'h0000, 3'b010, 16'hDEAD, 3'b000));
    vecs.push_back(mk(3'b001, 3'b000, 3'b000, 12'h005, 12'h000, 12'h000, 16'h0000, 3'b001, 1'b1, 1'b0, 8'h05, 16'h0000, 3'b100, 16'h2222, 3'b000));
    // Allocator writes car with lock, then cdr without; evaluator stalls in between.
    vecs.push_back(mk(3'b011, 3'b010, 3'b010, 12'h005, 12'h004, 12'h000, 16'h0002, 3'b010, 1'b1, 1'b1, 8'h04, 16'h0002, 3'b001, 16'h5555, 3'b000));
    vecs.push_back(mk(3'b011, 3'b000, 3'b010, 12'h005, 12'h003, 12'h000, 16'h0001, 3'b010, 1'b1, 1'b1, 8'h03, 16'h0001, 3'b010, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b001, 3'b000, 3'b000, 12'h004, 12'h000, 12'h000, 16'h0000, 3'b001, 1'b1, 1'b0, 8'h04, 16'h0000, 3'b010, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b001, 3'b000, 3'b000, 12'h003, 12'h000, 12'h000, 16'h0000, 3'b001, 1'b1, 1'b0, 8'h03, 16'h0000, 3'b001, 16'h0002, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b001, 16'h0001, 3'b000));
    // Evaluator takes the lock, goes idle holding it; loader waits until the lock falls.
    vecs.push_back(mk(3'b001, 3'b001, 3'b000, 12'h001, 12'h000, 12'h000, 16'h0000, 3'b001, 1'b1, 1'b0, 8'h01, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b100, 3'b001, 3'b000, 12'h000, 12'h000, 12'h002, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b001, 16'hDEAD, 3'b000));
    vecs.push_back(mk(3'b100, 3'b001, 3'b000, 12'h000, 12'h000, 12'h002, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b100, 3'b001, 3'b000, 12'h000, 12'h000, 12'h002, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h002, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h002, 16'h0000, 3'b100, 1'b1, 1'b0, 8'h02, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b100, 16'h2222, 3'b000));
    // Out-of-range read by the loader.
    vecs.push_back(mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h100, 16'h0000, 3'b100, BC_EN, 1'b0, 8'h00, 16'h0000, 3'b000, 16'h0000, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h00, 16'h0000, 3'b100, BC_RD, BC_ERR));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].lock, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].wd);
      @(negedge clk);
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
      check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      check($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwd));
      check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
      check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rd));
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].er));
      @(posedge clk);
      #1;
    end

    check("car at 0x004", 32'(tbmem[4]), 32'h0002);
    check("cdr at 0x003", 32'(tbmem[3]), 32'h0001);

    // Reset in the cycle after a locked read: response dropped, owner and rr_ptr restored.
    drive(3'b001, 3'b001, 3'b000, 12'h001, 12'h002, 12'h005, 16'h0);
    @(negedge clk);
    check("rst seq gnt", 32'(gnt), 32'b001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(3'b010, 3'b000, 3'b000, 12'h001, 12'h002, 12'h005, 16'h0);
    @(negedge clk);
    check_all_zero("mid reset");
    @(posedge clk);
    #1;
    check_all_zero("mid reset edge");
    rst_n = 1'b1;
    drive(3'b111, 3'b000, 3'b000, 12'h001, 12'h002, 12'h005, 16'h0);
    @(negedge clk);
    check("post reset gnt", 32'(gnt), 32'b001);
    check("post reset rvalid", 32'(rvalid), 32'b000);
    @(posedge clk);
    #1;
    drive(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 16'h0);
    @(negedge clk);
    check("post reset rvalid n+1", 32'(rvalid), 32'b001);
    check("post reset rdata n+1", 32'(rdata), 32'hDEAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
